// File: rtl/id_ex_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : id_ex_pipe
//  Description : ID/EX pipeline register for a 5-stage MIPS core. Resolves
//                the two ID operands ($0 forced to zero, same-cycle WB
//                bypass), detects load-use hazards and inserts a single
//                bubble, and honours a taken-branch flush from EX.
//                Optional macro ID_EX_PERF_CNT_EN adds saturating
//                perf_bubbles / perf_flushes counters.
//  Revision    : 1.0  initial release
// ============================================================================
module id_ex_pipe #(
    parameter int CTRL_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ID_valid,
    input  logic [4:0]        ID_rs,
    input  logic [4:0]        ID_rt,
    input  logic [31:0]       ID_rd1,
    input  logic [31:0]       ID_rd2,
    input  logic [4:0]        ID_dest,
    input  logic              ID_wen,
    input  logic              ID_mem_read,
    input  logic [31:0]       ID_imm,
    input  logic [CTRL_W-1:0] ID_ctrl,
    input  logic [4:0]        WB_rd,
    input  logic [31:0]       WB_wdata,
    input  logic              WB_wen,
    input  logic              EX_flush,
    output logic              ID_stall,
    output logic              EX_valid,
    output logic [31:0]       EX_rs_val,
    output logic [31:0]       EX_rt_val,
    output logic [4:0]        EX_rs,
    output logic [4:0]        EX_rt,
    output logic [4:0]        EX_dest,
    output logic              EX_wen,
    output logic              EX_mem_read,
    output logic [31:0]       EX_imm,
`ifdef ID_EX_PERF_CNT_EN
    output logic [CTRL_W-1:0] EX_ctrl,
    output logic [31:0]       perf_bubbles,
    output logic [31:0]       perf_flushes
`else
    output logic [CTRL_W-1:0] EX_ctrl
`endif
);

    localparam logic [31:0] c_CNT_MAX = 32'hFFFF_FFFF;

    // Registered EX-stage state
    logic              r_valid;
    logic [31:0]       r_rs_val;
    logic [31:0]       r_rt_val;
    logic [4:0]        r_rs;
    logic [4:0]        r_rt;
    logic [4:0]        r_dest;
    logic              r_wen;
    logic              r_mem_read;
    logic [31:0]       r_imm;
    logic [CTRL_W-1:0] r_ctrl;

    // Combinational ID-side signals
    logic [31:0]       w_rs_val;
    logic [31:0]       w_rt_val;
    logic              w_hz;
    logic              w_bubble;

    // Operand resolution: $0 reads as zero, otherwise a same-cycle writeback
    // to the same register overrides the (not yet updated) register file.
    always_comb begin
        w_rs_val = ID_rd1;
        if (ID_rs == 5'd0) begin
            w_rs_val = 32'h0;
        end else if (WB_wen && (WB_rd == ID_rs)) begin
            w_rs_val = WB_wdata;
        end

        w_rt_val = ID_rd2;
        if (ID_rt == 5'd0) begin
            w_rt_val = 32'h0;
        end else if (WB_wen && (WB_rd == ID_rt)) begin
            w_rt_val = WB_wdata;
        end
    end

    // Load-use hazard: a valid load in EX targets a register the ID
    // instruction reads. Depends only on registered EX state and ID numbers.
    assign w_hz = r_valid & r_mem_read & r_wen & (r_dest != 5'd0) & ID_valid &
                  ((r_dest == ID_rs) | (r_dest == ID_rt));

    // A flush kills the ID instruction, so no stall is needed in that cycle.
    assign w_bubble = w_hz & ~EX_flush;
    assign ID_stall = w_bubble;

    // EX register update: reset, then flush, then bubble, then normal load.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid    <= 1'b0;
            r_rs_val   <= 32'h0;
            r_rt_val   <= 32'h0;
            r_rs       <= 5'd0;
            r_rt       <= 5'd0;
            r_dest     <= 5'd0;
            r_wen      <= 1'b0;
            r_mem_read <= 1'b0;
            r_imm      <= 32'h0;
            r_ctrl     <= '0;
        end else if (EX_flush) begin
            r_valid    <= 1'b0;
            r_rs_val   <= 32'h0;
            r_rt_val   <= 32'h0;
            r_rs       <= 5'd0;
            r_rt       <= 5'd0;
            r_dest     <= 5'd0;
            r_wen      <= 1'b0;
            r_mem_read <= 1'b0;
            r_imm      <= 32'h0;
            r_ctrl     <= '0;
        end else begin
            // Payload always follows ID; only the qualifiers differ on a bubble.
            r_rs_val   <= w_rs_val;
            r_rt_val   <= w_rt_val;
            r_rs       <= ID_rs;
            r_rt       <= ID_rt;
            r_dest     <= ID_dest;
            r_imm      <= ID_imm;
            r_ctrl     <= ID_ctrl;
            if (w_hz) begin
                r_valid    <= 1'b0;
                r_wen      <= 1'b0;
                r_mem_read <= 1'b0;
            end else begin
                r_valid    <= ID_valid;
                r_wen      <= ID_valid & ID_wen;
                r_mem_read <= ID_valid & ID_mem_read;
            end
        end
    end

    assign EX_valid    = r_valid;
    assign EX_rs_val   = r_rs_val;
    assign EX_rt_val   = r_rt_val;
    assign EX_rs       = r_rs;
    assign EX_rt       = r_rt;
    assign EX_dest     = r_dest;
    assign EX_wen      = r_wen;
    assign EX_mem_read = r_mem_read;
    assign EX_imm      = r_imm;
    assign EX_ctrl     = r_ctrl;

`ifdef ID_EX_PERF_CNT_EN
    logic [31:0] r_perf_bubbles;
    logic [31:0] r_perf_flushes;

    // Saturating count of inserted hazard bubbles.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_perf_bubbles <= 32'h0;
        end else if (w_bubble && (r_perf_bubbles != c_CNT_MAX)) begin
            r_perf_bubbles <= r_perf_bubbles + 32'd1;
        end
    end

    // Saturating count of flush cycles outside reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_perf_flushes <= 32'h0;
        end else if (EX_flush && (r_perf_flushes != c_CNT_MAX)) begin
            r_perf_flushes <= r_perf_flushes + 32'd1;
        end
    end

    assign perf_bubbles = r_perf_bubbles;
    assign perf_flushes = r_perf_flushes;
`else
    // Counters absent; the saturation constant is referenced only there.
    logic w_unused_cnt;
    assign w_unused_cnt = &c_CNT_MAX;
`endif

endmodule
`default_nettype wire
